// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int LINE_BITS_DEF    = 128;
    localparam int LADDR_BITS_DEF   = 16;
    localparam int STARVE_LIMIT_DEF = 8;

    // Arbiter FSM: one idle state plus one busy state per requester.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_WB  = 2'd1,
        ST_BUSY_DRD = 2'd2,
        ST_BUSY_IRD = 2'd3
    } arb_state_e;

    // Grant decision taken in IDLE.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_DRD  = 2'd2,
        GNT_IRD  = 2'd3
    } gnt_e;

    // One bit per requester; used for eligibility and the post-service mask.
    typedef struct packed {
        logic wb;
        logic drd;
        logic ird;
    } req_vec_t;

    // Fixed priority WB > DRD > IRD; a starved I-fill jumps to the front.
    // WB ahead of DRD keeps an eviction ahead of the refill that replaces it.
    function automatic gnt_e select_grant(input req_vec_t elig, input logic starved);
        if (starved && elig.ird) return GNT_IRD;
        if (elig.wb)             return GNT_WB;
        if (elig.drd)            return GNT_DRD;
        if (elig.ird)            return GNT_IRD;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// slave: the arbiter's view; master: the caches/memory environment.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int LINE_BITS  = LINE_BITS_DEF,
    parameter int LADDR_BITS = LADDR_BITS_DEF
);

    // I-cache line fill
    logic                  Ic_mem_req;
    logic [LADDR_BITS-1:0] Ic_mem_addr;
    logic [LINE_BITS-1:0]  F_mem_inst;
    logic                  F_mem_valid;

    // D-cache line fill (also carries page-table walks)
    logic                  Dc_mem_req;
    logic [LADDR_BITS-1:0] Dc_mem_addr;
    logic [LINE_BITS-1:0]  MEM_data_line;
    logic                  MEM_mem_valid;

    // D-cache dirty-line write-back
    logic                  Dc_wb_we;
    logic [LADDR_BITS-1:0] Dc_wb_addr;
    logic [LINE_BITS-1:0]  Dc_wb_wline;
    logic                  Dc_wb_done;

    // Unified memory port
    logic                  Arb_mem_req;
    logic                  Arb_mem_we;
    logic [LADDR_BITS-1:0] Arb_mem_addr;
    logic [LINE_BITS-1:0]  Arb_mem_wline;
    logic [LINE_BITS-1:0]  Arb_mem_rline;
    logic                  Arb_mem_valid;

    modport slave (
        input  Ic_mem_req, Ic_mem_addr,
        output F_mem_inst, F_mem_valid,
        input  Dc_mem_req, Dc_mem_addr,
        output MEM_data_line, MEM_mem_valid,
        input  Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        output Dc_wb_done,
        output Arb_mem_req, Arb_mem_we, Arb_mem_addr, Arb_mem_wline,
        input  Arb_mem_rline, Arb_mem_valid
    );

    modport master (
        output Ic_mem_req, Ic_mem_addr,
        input  F_mem_inst, F_mem_valid,
        output Dc_mem_req, Dc_mem_addr,
        input  MEM_data_line, MEM_mem_valid,
        output Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        input  Dc_wb_done,
        input  Arb_mem_req, Arb_mem_we, Arb_mem_addr, Arb_mem_wline,
        output Arb_mem_rline, Arb_mem_valid
    );

endinterface

// File: rtl/mem_arb_age_ctr.sv
// Saturating count of cycles an I-fill has been waiting for the memory port.
// starved rises once the count reaches LIMIT.
module mem_arb_age_ctr #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req,      // I-fill request pending
    input  logic inc_en,   // I-fill not currently being served
    input  logic clr,      // I-fill granted this cycle
    output logic starved
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Age register: cleared on grant or when no I-fill is pending, else saturating increment.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst || clr || !req) begin
            count <= '0;
        end else if (inc_en && (count < CW'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    assign starved = (count >= CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single line-wide port of the unified memory between the
// I-cache fill, the D-cache fill and the D-cache write-back. One transaction
// is in flight at a time; each completion is followed by one IDLE cycle in
// which the served requester is masked while it retires its request.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_BITS    = LINE_BITS_DEF,
    parameter int LADDR_BITS   = LADDR_BITS_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e            state;
    arb_state_e            state_nxt;
    req_vec_t              mask_q;
    req_vec_t              mask_nxt;
    req_vec_t              elig;
    gnt_e                  gnt;
    logic                  starved;
    logic                  grant_fire;
    logic                  grant_ird;
    logic                  age_inc_en;
    logic                  done_wb;
    logic                  done_drd;
    logic                  done_ird;
    logic [LADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0]  wline_q;

    // A requester still holding req in the cycle after its completion is not
    // a new request; the mask hides it for exactly that cycle.
    assign elig.wb  = bus.Dc_wb_we   & ~mask_q.wb;
    assign elig.drd = bus.Dc_mem_req & ~mask_q.drd;
    assign elig.ird = bus.Ic_mem_req & ~mask_q.ird;

    assign gnt        = select_grant(elig, starved);
    assign grant_fire = (state == ST_IDLE) && (gnt != GNT_NONE);
    assign grant_ird  = (state == ST_IDLE) && (gnt == GNT_IRD);
    assign age_inc_en = (state != ST_BUSY_IRD);

    mem_arb_age_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_age (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.Ic_mem_req),
        .inc_en  (age_inc_en),
        .clr     (grant_ird),
        .starved (starved)
    );

    // Memory completions only count in the matching busy state; a stray
    // Arb_mem_valid in IDLE produces nothing.
    assign done_wb  = (state == ST_BUSY_WB)  && bus.Arb_mem_valid;
    assign done_drd = (state == ST_BUSY_DRD) && bus.Arb_mem_valid;
    assign done_ird = (state == ST_BUSY_IRD) && bus.Arb_mem_valid;

    // Next-state and next-mask selection.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_nxt = state;
        mask_nxt  = '0;
        unique case (state)
            ST_IDLE: begin
                unique case (gnt)
                    GNT_WB:   state_nxt = ST_BUSY_WB;
                    GNT_DRD:  state_nxt = ST_BUSY_DRD;
                    GNT_IRD:  state_nxt = ST_BUSY_IRD;
                    default:  state_nxt = ST_IDLE;
                endcase
            end
            ST_BUSY_WB: begin
                if (done_wb) begin
                    state_nxt   = ST_IDLE;
                    mask_nxt.wb = 1'b1;
                end
            end
            ST_BUSY_DRD: begin
                if (done_drd) begin
                    state_nxt    = ST_IDLE;
                    mask_nxt.drd = 1'b1;
                end
            end
            ST_BUSY_IRD: begin
                if (done_ird) begin
                    state_nxt    = ST_IDLE;
                    mask_nxt.ird = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, mask and the registered request captured on the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mask_q  <= '0;
            // NOTE: the address/data holding registers are reset too because they drive outputs that must read 0 after reset.
            addr_q  <= '0;
            wline_q <= '0;
        end else begin
            state  <= state_nxt;
            mask_q <= mask_nxt;
            if (grant_fire) begin
                unique case (gnt)
                    GNT_WB: begin
                        addr_q  <= bus.Dc_wb_addr;
                        wline_q <= bus.Dc_wb_wline;
                    end
                    GNT_DRD: addr_q <= bus.Dc_mem_addr;
                    GNT_IRD: addr_q <= bus.Ic_mem_addr;
                    default: addr_q <= addr_q;
                endcase
            end
        end
    end

    // Memory-side outputs: address and data stay frozen for the whole busy phase.
    assign bus.Arb_mem_req   = (state != ST_IDLE);
    assign bus.Arb_mem_we    = (state == ST_BUSY_WB);
    assign bus.Arb_mem_addr  = addr_q;
    assign bus.Arb_mem_wline = wline_q;

    // Requester-side completions: read data passes straight through, gated to zero.
    assign bus.F_mem_valid   = done_ird;
    assign bus.F_mem_inst    = done_ird ? bus.Arb_mem_rline : '0;
    assign bus.MEM_mem_valid = done_drd;
    assign bus.MEM_data_line = done_drd ? bus.Arb_mem_rline : '0;
    assign bus.Dc_wb_done    = done_wb;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single line-wide port of the unified instruction/data memory between three requesters:
- the I-cache line fill,
- the D-cache line fill (which also carries PTW walks through the D-cache),
- the D-cache dirty-line write-back.

It sits between the caches and the unified memory. It serialises their transactions through a small FSM, using fixed priority plus an I-side anti-starvation counter.

## Interface
Parameters:
- LINE_BITS, 128, cache line width
- LADDR_BITS, 16, line address width (PC_BITS-4)
- STARVE_LIMIT, 8, wait cycles after which a pending I-fill is promoted to top priority

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Ic_mem_req  in  1  I-cache line-read request, held until F_mem_valid
- Ic_mem_addr  in  LADDR_BITS  I-cache line address
- F_mem_inst  out  LINE_BITS  line returned to I-cache, zero unless F_mem_valid
- F_mem_valid  out  1  one-cycle completion pulse for I-fill
- Dc_mem_req  in  1  D-cache line-read request, held until MEM_mem_valid
- Dc_mem_addr  in  LADDR_BITS  D-cache read line address
- MEM_data_line  out  LINE_BITS  line returned to D-cache, zero unless MEM_mem_valid
- MEM_mem_valid  out  1  one-cycle completion pulse for D-fill
- Dc_wb_we  in  1  write-back request, held until Dc_wb_done
- Dc_wb_addr  in  LADDR_BITS  write-back line address
- Dc_wb_wline  in  LINE_BITS  write-back data
- Dc_wb_done  out  1  one-cycle completion pulse for write-back
- Arb_mem_req  out  1  transaction active toward memory
- Arb_mem_we  out  1  1 = line write, 0 = line read
- Arb_mem_addr  out  LADDR_BITS  registered line address
- Arb_mem_wline  out  LINE_BITS  registered write data
- Arb_mem_rline  in  LINE_BITS  read data, valid with Arb_mem_valid
- Arb_mem_valid  in  1  one-cycle completion pulse from memory, for reads and writes

## Operation
- FSM states: IDLE, BUSY_WB, BUSY_DRD, BUSY_IRD.
- **IDLE:** evaluates eligible requests. A requester is eligible if its req is high and it is not masked.
  - Normal priority: WB > DRD > IRD.
  - When age_ctr >= STARVE_LIMIT: IRD > WB > DRD.
  - If nothing is eligible, stay in IDLE.
- **Grant:** on the IDLE→BUSY_x edge, register the winner's address and, for WB only, its line and we=1.
- **BUSY_x:**
  - Arb_mem_req=1; address, write data and we are held constant.
  - On Arb_mem_valid, pulse the matching completion output in the same cycle (combinational pass-through of Arb_mem_rline for reads).
  - Then go to IDLE and set a one-cycle mask on the served requester. The mask covers the cycle in which the requester drops its req.
- **age_ctr:**
  - Increments (saturating at STARVE_LIMIT) each cycle Ic_mem_req=1 and state≠BUSY_IRD.
  - Clears on the IDLE→BUSY_IRD edge.
  - Holds 0 while Ic_mem_req=0.
- **Simultaneous WB and DRD from the D-cache:** WB is always served first (evict before refill).
- **Arb_mem_valid outside BUSY_x:** ignored; no completion pulse.
- **Reset:**
  - All outputs go to 0, state to IDLE, age_ctr and mask to 0.
  - A reset in mid-transaction abandons it with no completion pulse; memory is reset by the same rst.

## Timing
- Request seen in IDLE at cycle t → Arb_mem_req=1 from t+1.
- Memory with LATENCY L pulses Arb_mem_valid at t+1+L. The completion pulse appears in that same cycle.
- FSM is in IDLE at t+2+L, so back-to-back grants cost one IDLE cycle between transactions.
- A 3-cycle memory gives a 4-cycle request-to-data time per fill when uncontended.
- Worst-case I-fill wait is bounded by STARVE_LIMIT plus one in-flight transaction.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum,
  - grant codes (GNT_NONE/WB/DRD/IRD),
  - LINE_BITS/LADDR_BITS defaults.
- One sub-module, mem_arb_age_ctr: the saturating starvation counter with clear and compare output.
- Priority select and FSM stay in the top.

## Test plan
- **Lone I-fill:** Ic_mem_req=1, addr 0x0012 at t, memory L=3 → Arb_mem_req/addr 0x0012 at t+1, we=0; F_mem_valid with the memory line at t+4; Arb_mem_req=0 at t+5.
- **Simultaneous WB and DRD:**
  - Stimulus: Dc_wb_we addr 0x0040 data 0xA5…A5, plus Dc_mem_req addr 0x0041.
  - Response: first transaction is a write to 0x0040 with that line and Dc_wb_done; then a read of 0x0041 with MEM_mem_valid; never reversed.
- **Starvation:**
  - Stimulus: STARVE_LIMIT=8, Ic_mem_req held, D-cache reissuing DRD continuously.
  - Response: IRD is granted at the first IDLE after age_ctr reaches 8, ahead of the pending DRD; age_ctr reads 0 the cycle after that grant.
- **Mask:** a requester holds req one cycle past its valid pulse → no second grant for it; another pending requester is granted instead, or the FSM stays IDLE.
- **Reset mid-transaction:** rst=1 in BUSY_DRD before Arb_mem_valid → next cycle all outputs 0, state IDLE; no MEM_mem_valid pulse ever appears for that request.
- **Spurious valid:** Arb_mem_valid pulsed in IDLE → F_mem_valid, MEM_mem_valid and Dc_wb_done stay 0; state unchanged.
